// File: rtl/hazard_unit_mc.sv
// Hazard unit for the five-stage RV32 pipeline with a multi-cycle MUL/DIV op in E:
// forwarding, load-use stall, multi-cycle hold of F/D/E, and saturating stall/flush counters.
//
//   state  | meaning
//   IDLE   | no multi-cycle op in progress; McStartE may launch one
//   BUSY   | op held in E; mc_cnt counts the remaining stall cycles
module hazard_unit_mc #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16,
    parameter int REG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             McStartE,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             lwStall,
    output logic             McBusy,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int            CW      = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam bit            MC_EN   = (MC_LAT > 1);
    localparam logic [CW-1:0] MC_LOAD = CW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_mc_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mc_stall;
    logic w_ld_use;
    logic w_lw_stall;
    logic w_stall_fd;
    logic w_flush_e;
    logic w_unused_rsrc;

    assign w_unused_rsrc = ResultSrcE[1];

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_m,
        input logic             we_m,
        input logic [REG_W-1:0] rd_w,
        input logic             we_w
    );
        if (rs != '0 && rs == rd_m && we_m)      return 2'b10;
        else if (rs != '0 && rs == rd_w && we_w) return 2'b01;
        else                                     return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    // Gated by rst_n so a McStartE seen during reset cannot hold or bubble the pipe.
    always_comb begin
        w_mc_stall = 1'b0;
        if (rst_n) begin
            if (r_state == S_IDLE) w_mc_stall = McStartE & MC_EN;
            else                   w_mc_stall = (r_mc_cnt != '0);
        end
    end

    assign w_ld_use   = ResultSrcE[0] & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
    assign w_lw_stall = w_ld_use & ~w_mc_stall;
    assign w_stall_fd = w_lw_stall | w_mc_stall;
    assign w_flush_e  = (w_lw_stall | PCSrcE) & ~w_mc_stall;

    assign lwStall = w_lw_stall;
    assign StallF  = w_stall_fd;
    assign StallD  = w_stall_fd;
    assign StallE  = w_mc_stall;
    assign FlushM  = w_mc_stall;
    assign FlushD  = PCSrcE & ~w_mc_stall;
    assign FlushE  = w_flush_e;
    assign McBusy  = (r_state == S_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mc_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (McStartE && MC_EN) begin
                        r_state  <= S_BUSY;
                        r_mc_cnt <= MC_LOAD;
                    end
                end
                S_BUSY: begin
                    if (r_mc_cnt == '0) r_state  <= S_IDLE;
                    else                r_mc_cnt <= r_mc_cnt - CW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Clear wins over an event in the same cycle; counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (CntClr)                            r_stall_cnt <= '0;
            else if (w_stall_fd && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (CntClr)                            r_flush_cnt <= '0;
            else if (w_flush_e && r_flush_cnt != '1)  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: a MC_LAT=4 instance and a MC_LAT=1 instance share stimulus;
// expected outputs go through a scoreboard queue and are compared when sampled.
module tb_hazard_unit_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, McStartE, CntClr;

    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic       a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_lw, a_busy;
    logic       b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_lw, b_busy;
    logic [2:0] a_sc, a_fc, b_sc, b_fc;

    hazard_unit_mc #(.MC_LAT(4), .CNT_W(3), .REG_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE), .CntClr(CntClr),
        .ForwardAE(a_fa), .ForwardBE(a_fb), .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
        .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .lwStall(a_lw), .McBusy(a_busy),
        .StallCnt(a_sc), .FlushCnt(a_fc)
    );

    hazard_unit_mc #(.MC_LAT(1), .CNT_W(3), .REG_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McStartE(McStartE), .CntClr(CntClr),
        .ForwardAE(b_fa), .ForwardBE(b_fb), .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
        .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .lwStall(b_lw), .McBusy(b_busy),
        .StallCnt(b_sc), .FlushCnt(b_fc)
    );

    logic [11:0] a_out, b_out;
    assign a_out = {a_fa, a_fb, a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_lw, a_busy};
    assign b_out = {b_fa, b_fb, b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_lw, b_busy};

    typedef struct {
        string       name;
        bit          sel;
        logic [11:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        rwm, rww;
        logic [1:0]  rsrc;
        logic        pc;
        logic [11:0] exp;
    } vec_t;
    vec_t vt[13];

    int n_chk  = 0;
    int n_fail = 0;

    // Packed as {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, lwStall, McBusy}
    function automatic logic [11:0] pk(input logic [1:0] fa, input logic [1:0] fb, input logic sf,
                                       input logic se, input logic fd, input logic fe,
                                       input logic fm, input logic lw, input logic busy);
        return {fa, fb, sf, sf, se, fd, fe, fm, lw, busy};
    endfunction

    // Expected outputs with forwarding idle, given the mcStall/BUSY the FSM should be in.
    function automatic logic [11:0] eq(input logic mcs, input logic busy, input logic ld, input logic pc);
        logic lw;
        lw = ld & ~mcs;
        return pk(2'b00, 2'b00, lw | mcs, mcs, pc & ~mcs, (lw | pc) & ~mcs, mcs, lw, busy);
    endfunction

    function automatic vec_t mkv(input logic [4:0] rs1d, input logic [4:0] rs2d, input logic [4:0] rs1e,
                                 input logic [4:0] rs2e, input logic [4:0] rde, input logic [4:0] rdm,
                                 input logic [4:0] rdw, input logic rwm, input logic rww,
                                 input logic [1:0] rsrc, input logic pc, input logic [11:0] exp);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww; v.rsrc = rsrc; v.pc = pc; v.exp = exp;
        return v;
    endfunction

    task automatic expect_out(input string nm, input bit sel, input logic [11:0] e);
        sb_t t;
        t.name = nm; t.sel = sel; t.exp = e;
        sb_q.push_back(t);
    endtask

    task automatic score();
        sb_t         t;
        logic [11:0] act;
        while (sb_q.size() > 0) begin
            t   = sb_q.pop_front();
            act = t.sel ? b_out : a_out;
            n_chk++;
            if (act !== t.exp) begin
                n_fail++;
                $display("FAIL %s: got %03h expected %03h", t.name, act, t.exp);
            end
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [2:0] act, input logic [2:0] e);
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, e);
        end
    endtask

    task automatic set_in(input logic ld, input logic pc, input logic mc);
        Rs1D = ld ? 5'd7 : 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = ld ? 5'd7 : 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = ld ? 2'b01 : 2'b00;
        PCSrcE = pc; McStartE = mc;
    endtask

    // One clock cycle, entered and left just after a rising edge.
    task automatic cyc(input string nm, input logic mc, input logic ld, input logic pc,
                       input logic a_mcs, input logic a_bsy);
        set_in(ld, pc, mc);
        expect_out(nm, 1'b0, eq(a_mcs, a_bsy, ld, pc));
        expect_out({nm, "_lat1"}, 1'b1, eq(1'b0, 1'b0, ld, pc));
        @(negedge clk);
        score();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0]  = mkv(0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, pk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vt[1]  = mkv(0, 0, 5, 0, 0, 5, 5, 0, 1, 2'b00, 0, pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vt[2]  = mkv(0, 0, 0, 0, 0, 5, 5, 0, 1, 2'b00, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vt[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vt[4]  = mkv(0, 0, 0, 5, 0, 5, 5, 1, 1, 2'b00, 0, pk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        vt[5]  = mkv(0, 0, 0, 5, 0, 5, 5, 0, 1, 2'b00, 0, pk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        vt[6]  = mkv(0, 0, 0, 0, 0, 5, 5, 0, 1, 2'b00, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vt[7]  = mkv(0, 0, 5, 9, 0, 9, 5, 1, 1, 2'b00, 0, pk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        vt[8]  = mkv(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, pk(2'b00, 2'b00, 1, 0, 0, 1, 0, 1, 0));
        vt[9]  = mkv(0, 7, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vt[10] = mkv(7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b01, 1, pk(2'b00, 2'b00, 1, 0, 1, 1, 0, 1, 0));
        vt[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, pk(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0));
        vt[12] = mkv(7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

        // Reset with McStartE high: nothing may stall, FSM and counters at zero.
        rst_n  = 1'b0;
        CntClr = 1'b0;
        set_in(1'b0, 1'b0, 1'b1);
        #2;
        expect_out("reset_state", 1'b0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        expect_out("reset_state_lat1", 1'b1, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        score();
        chk_cnt("reset_stallcnt", a_sc, 3'd0);
        chk_cnt("reset_flushcnt", a_fc, 3'd0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e;
            RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
            RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
            ResultSrcE = vt[i].rsrc; PCSrcE = vt[i].pc; McStartE = 1'b0;
            expect_out($sformatf("vec%0d", i), 1'b0, vt[i].exp);
            expect_out($sformatf("vec%0d_lat1", i), 1'b1, vt[i].exp);
            #2;
            score();
        end
        @(posedge clk); #1;

        // Two back-to-back multi-cycle ops.
        cyc("mc_c0", 1, 0, 0, 1, 0);
        cyc("mc_c1", 1, 0, 0, 1, 1);
        cyc("mc_c2", 1, 0, 0, 1, 1);
        cyc("mc_c3", 1, 0, 0, 0, 1);
        cyc("mc_c4", 1, 0, 0, 1, 0);
        cyc("mc_c5", 1, 0, 0, 1, 1);
        cyc("mc_c6", 1, 0, 0, 1, 1);
        cyc("mc_c7", 1, 0, 0, 0, 1);
        cyc("mc_c8", 0, 0, 0, 0, 0);

        // Load-use and taken branch while the op is held.
        cyc("int_c0", 1, 0, 0, 1, 0);
        cyc("int_c1", 1, 1, 1, 1, 1);
        cyc("int_c2", 0, 1, 1, 1, 1);
        cyc("int_c3", 0, 1, 1, 0, 1);
        cyc("int_c4", 0, 0, 0, 0, 0);

        // Reset during BUSY abandons the op; a fresh op then runs its full stall.
        cyc("rst_c0", 1, 0, 0, 1, 0);
        set_in(1'b0, 1'b0, 1'b1);
        expect_out("rst_c1", 1'b0, eq(1'b1, 1'b1, 1'b0, 1'b0));
        #2;
        score();
        rst_n = 1'b0;
        #1;
        expect_out("rst_asserted", 1'b0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        expect_out("rst_asserted_lat1", 1'b1, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        score();
        chk_cnt("rst_mid_stallcnt", a_sc, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("rst_r0", 1, 0, 0, 1, 0);
        cyc("rst_r1", 1, 0, 0, 1, 1);
        cyc("rst_r2", 1, 0, 0, 1, 1);
        cyc("rst_r3", 1, 0, 0, 0, 1);
        cyc("rst_r4", 0, 0, 0, 0, 0);

        // Counters: saturation, clear priority, flush counting.
        set_in(1'b0, 1'b0, 1'b0);
        CntClr = 1'b1;
        @(posedge clk); #1;
        CntClr = 1'b0;
        chk_cnt("cnt_clr_stall", a_sc, 3'd0);
        chk_cnt("cnt_clr_flush", a_fc, 3'd0);
        set_in(1'b1, 1'b0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        chk_cnt("cnt_stall_5", a_sc, 3'd5);
        chk_cnt("cnt_flush_5", a_fc, 3'd5);
        repeat (5) begin @(posedge clk); #1; end
        chk_cnt("cnt_stall_sat", a_sc, 3'd7);
        chk_cnt("cnt_flush_sat", a_fc, 3'd7);
        chk_cnt("cnt_stall_sat_lat1", b_sc, 3'd7);
        CntClr = 1'b1;
        @(posedge clk); #1;
        CntClr = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        chk_cnt("cnt_clr_vs_stall", a_sc, 3'd0);
        chk_cnt("cnt_clr_vs_flush", a_fc, 3'd0);
        @(posedge clk); #1;
        chk_cnt("cnt_idle_hold", a_sc, 3'd0);
        repeat (3) begin
            set_in(1'b0, 1'b1, 1'b0);
            @(posedge clk); #1;
            set_in(1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        chk_cnt("cnt_pcsrc_flush", a_fc, 3'd3);
        chk_cnt("cnt_pcsrc_stall", a_sc, 3'd0);
        chk_cnt("cnt_pcsrc_flush_lat1", b_fc, 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
